// File: rtl/progmem_arb.sv
// progmem_arb: round-robin arbiter for port A of the progmem program memory.
// m0 is the CPU fetch path (read-only). m1 is the JTAG debug loader (read/write).
// Optional zero-fill clear engine, built when PROGMEM_ARB_CLEAR_EN is defined.
// Grants and RAM-side controls are combinational. rvalid, clr_busy and clr_done
// are registered. Synchronous, active-high reset.
module progmem_arb #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state;
  // 1: m1 held the most recent grant, so m0 wins the next tie
  logic   last;

`ifdef PROGMEM_ARB_CLEAR_EN
  // One bit wider than the address so the terminal compare is unambiguous
  localparam logic [AW:0] CLR_LAST = {1'b0, {AW{1'b1}}};
  logic [AW:0] cnt;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
`endif

  // Read data goes straight from the RAM. It is meaningful only while rvalid is high.
  assign m0_rdata = ram_dout;
  assign m1_rdata = ram_dout;

  // Round-robin arbitration. It runs only in IDLE and not during reset.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst && state == IDLE) begin
      if (m0_req && m1_req) begin
        if (last) m0_gnt = 1'b1;
        else      m1_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  // RAM port A drive. The clear engine owns the port in CLEAR, otherwise the winner does.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst) begin
`ifdef PROGMEM_ARB_CLEAR_EN
      if (state == CLEAR) begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cnt[AW-1:0];
        ram_din  = '0;
      end else
`endif
      if (m0_gnt) begin
        ram_en   = 1'b1;
        ram_addr = m0_addr;
      end else if (m1_gnt) begin
        ram_en   = 1'b1;
        ram_we   = m1_we;
        ram_addr = m1_addr;
        ram_din  = m1_wdata;
      end
    end
  end

  // Sequencer: round-robin history, read-valid pipeline and the clear FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
`ifdef PROGMEM_ARB_CLEAR_EN
      cnt       <= '0;
`endif
    end else begin
      m0_rvalid <= m0_gnt;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt)      last <= 1'b0;
      else if (m1_gnt) last <= 1'b1;
      clr_done <= 1'b0;
`ifdef PROGMEM_ARB_CLEAR_EN
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            cnt      <= '0;
          end
        end
        CLEAR: begin
          if (cnt == CLR_LAST) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          cnt      <= '0;
        end
      endcase
`else
      state    <= IDLE;
      clr_busy <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_progmem_arb.sv
// Self-checking bench for progmem_arb, with a behavioural read-first RAM model.
module tb_progmem_arb;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req, m1_we, clr_start;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, clr_busy, clr_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  progmem_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Port A of the program memory: synchronous read-first.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_addr = '0; m1_req = 1'b0; m1_we = 1'b0;
    m1_addr = '0; m1_wdata = '0; clr_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic m0_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    @(negedge clk);
    m0_req = 1'b1; m0_addr = a;
    #1 chk({name, "_gnt"}, 32'(m0_gnt), 32'd1);
    @(negedge clk);
    m0_req = 1'b0;
    #1 chk({name, "_rvalid"}, 32'(m0_rvalid), 32'd1);
    chk({name, "_rdata"}, m0_rdata, exp);
  endtask

  task automatic m1_write(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = a; m1_wdata = d;
    #1 chk({name, "_gnt"}, 32'(m1_gnt), 32'd1);
    chk({name, "_we"}, 32'(ram_we), 32'd1);
    @(negedge clk);
    m1_req = 1'b0; m1_we = 1'b0;
  endtask

  typedef struct {
    logic m0_req; logic [AW-1:0] m0_addr;
    logic m1_req; logic m1_we; logic [AW-1:0] m1_addr; logic [DW-1:0] m1_wdata;
    logic e_g0; logic e_g1; logic e_en; logic e_we;
    logic [AW-1:0] e_addr; logic [DW-1:0] e_din;
    logic e_rv0; logic e_rv1; logic [DW-1:0] e_rd0; logic [DW-1:0] e_rd1;
  } vec_t;

  vec_t vt [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'hD07F_FFFF;

    //            m0r   m0a     m1r   we    m1a     wdata          g0    g1    en    we    addr    din            rv0   rv1   rd0            rd1
    vt[0]  = '{1'b1, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 32'hD07FFFFF, 32'h0};
    vt[2]  = '{1'b1, 9'h001, 1'b1, 1'b0, 9'h002, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 9'h002, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vt[3]  = '{1'b1, 9'h001, 1'b1, 1'b0, 9'h002, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 9'h001, 32'h0,        1'b0, 1'b1, 32'h0,        32'hA5000002};
    vt[4]  = '{1'b1, 9'h001, 1'b1, 1'b0, 9'h002, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 9'h002, 32'h0,        1'b1, 1'b0, 32'hA5000001, 32'h0};
    vt[5]  = '{1'b1, 9'h001, 1'b1, 1'b0, 9'h002, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 9'h001, 32'h0,        1'b0, 1'b1, 32'h0,        32'hA5000002};
    vt[6]  = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h1FF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 9'h1FF, 32'hDEADBEEF, 1'b1, 1'b0, 32'hA5000001, 32'h0};
    vt[7]  = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h1FF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 9'h1FF, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vt[8]  = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b1, 32'h0,        32'hDEADBEEF};
    vt[9]  = '{1'b1, 9'h003, 1'b1, 1'b1, 9'h005, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0, 9'h003, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vt[10] = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h005, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 9'h005, 32'h12345678, 1'b1, 1'b0, 32'hA5000003, 32'h0};
    vt[11] = '{1'b1, 9'h005, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 9'h005, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vt[12] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 32'h12345678, 32'h0};

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_clr_done", 32'(clr_done), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);

    // A request held during reset is neither granted nor answered.
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 9'h004;
    #1 chk("rst_req_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_req_en", 32'(ram_en), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1 chk("rst_req_rvalid", 32'(m0_rvalid), 32'd0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      m0_req = vt[i].m0_req; m0_addr = vt[i].m0_addr;
      m1_req = vt[i].m1_req; m1_we = vt[i].m1_we;
      m1_addr = vt[i].m1_addr; m1_wdata = vt[i].m1_wdata;
      #1;
      chk($sformatf("v%0d_m0_gnt", i), 32'(m0_gnt), 32'(vt[i].e_g0));
      chk($sformatf("v%0d_m1_gnt", i), 32'(m1_gnt), 32'(vt[i].e_g1));
      chk($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vt[i].e_en));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d_ram_din", i), ram_din, vt[i].e_din);
      chk($sformatf("v%0d_m0_rvalid", i), 32'(m0_rvalid), 32'(vt[i].e_rv0));
      chk($sformatf("v%0d_m1_rvalid", i), 32'(m1_rvalid), 32'(vt[i].e_rv1));
      if (vt[i].e_rv0) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vt[i].e_rd0);
      if (vt[i].e_rv1) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vt[i].e_rd1);
    end
    @(negedge clk);
    idle_inputs();

    // After reset the first tie goes to m0, the next one to m1.
    do_reset();
    m0_req = 1'b1; m0_addr = 9'h010;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h011;
    #1 chk("tie1_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("tie1_m1_gnt", 32'(m1_gnt), 32'd0);
    @(negedge clk);
    #1 chk("tie2_m1_gnt", 32'(m1_gnt), 32'd1);
    chk("tie2_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("tie2_m0_rdata", m0_rdata, 32'hA5000010);
    @(negedge clk);
    idle_inputs();
    #1 chk("tie3_m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("tie3_m1_rdata", m1_rdata, 32'hA5000011);

`ifdef PROGMEM_ARB_CLEAR_EN
    begin
      int n;
      int bad;
      bit found;
      // Full clear with m0 requesting throughout. The read in the start cycle completes.
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 9'h000; clr_start = 1'b1;
      #1 chk("clr_start_m0_gnt", 32'(m0_gnt), 32'd1);
      chk("clr_start_busy", 32'(clr_busy), 32'd0);
      @(negedge clk);
      clr_start = 1'b0;
      #1 chk("clr_first_rvalid", 32'(m0_rvalid), 32'd1);
      chk("clr_first_rdata", m0_rdata, 32'hD07FFFFF);
      n = 0;
      bad = 0;
      while (clr_busy && n < 600) begin
        if (m0_gnt !== 1'b0 || ram_we !== 1'b1 || ram_en !== 1'b1 ||
            ram_din !== 32'h0 || ram_addr !== n[AW-1:0] || clr_done !== 1'b0)
          bad++;
        n++;
        @(negedge clk);
        #1;
      end
      chk("clr_cycle_errors", 32'(bad), 32'd0);
      chk("clr_busy_cycles", 32'(n), 32'd512);
      chk("clr_done_pulse", 32'(clr_done), 32'd1);
      chk("clr_after_m0_gnt", 32'(m0_gnt), 32'd1);
      @(negedge clk);
      m0_req = 1'b0;
      #1 chk("clr_done_gone", 32'(clr_done), 32'd0);
      chk("clr_read0_rvalid", 32'(m0_rvalid), 32'd1);
      chk("clr_read0_rdata", m0_rdata, 32'h0);
      m0_read("clr_read1ff", 9'h1FF, 32'h0);

      // Reset mid-clear
      m1_write("pre_w050", 9'h050, 32'h55AA55AA);
      m1_write("pre_w1ff", 9'h1FF, 32'hDEADBEEF);
      @(negedge clk);
      clr_start = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
        @(negedge clk);
        clr_start = 1'b0;
        #1;
        if (clr_busy && ram_addr == 9'd100) found = 1'b1;
      end
      chk("abort_reached_100", 32'(found), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("abort_busy", 32'(clr_busy), 32'd0);
      chk("abort_done", 32'(clr_done), 32'd0);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        #1;
        if (clr_done !== 1'b0 || clr_busy !== 1'b0) bad++;
      end
      chk("abort_no_done", 32'(bad), 32'd0);
      m0_read("abort_read050", 9'h050, 32'h0);
      m0_read("abort_read1ff", 9'h1FF, 32'hDEADBEEF);
    end
`else
    begin
      int bad;
      // Without the clear engine, clr_start has no effect.
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 9'h007; clr_start = 1'b1;
      #1 chk("noclr_gnt0", 32'(m0_gnt), 32'd1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        clr_start = 1'b0;
        #1;
        if (m0_gnt !== 1'b1 || clr_busy !== 1'b0 || clr_done !== 1'b0 ||
            m0_rvalid !== 1'b1 || m0_rdata !== 32'hA5000007) bad++;
      end
      chk("noclr_cycle_errors", 32'(bad), 32'd0);
      chk("noclr_busy", 32'(clr_busy), 32'd0);
      @(negedge clk);
      idle_inputs();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
